// File: rtl/cdc_pulse_scheduler.sv
// cdc_pulse_scheduler: round-robin serialiser of per-source event pulses onto one rate-limited toggle-CDC channel.
// Optional macro CDC_PULSE_SCHED_STATS_EN enables the 16-bit issued_cnt pulse counter (tied to 0 otherwise).
module cdc_pulse_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MIN_GAP = 6,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic               clr_ovf,
  output logic               pulse_out,
  output logic [ID_W-1:0]    pulse_id,
  output logic               busy,
  output logic [NUM_REQ-1:0] overflow,
  output logic [15:0]        issued_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  localparam int GW = $clog2(MIN_GAP + 1);
  // IDLE and ISSUE each take one cycle, so GAP fills the remaining MIN_GAP-2
  localparam logic [GW-1:0] GAP_LD = GW'(MIN_GAP > 2 ? MIN_GAP - 3 : 0);
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] nz, ovf_q, ovf_d;
  logic [ID_W-1:0]    ptr_q, gidx, id_q;
  logic [GW-1:0]      gap_q;
  logic               pulse_q, busy_q, grant;
  always_comb begin
    gidx = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) nz[i] = |cnt_q[i];
    // scan from the farthest candidate down so the nearest one after ptr wins
    for (int k = NUM_REQ; k >= 1; k--)
      if (nz[(int'(ptr_q) + k) % NUM_REQ]) gidx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
    grant = (state_q == IDLE) && (|nz);
    for (int i = 0; i < NUM_REQ; i++) begin
      ovf_d[i] = (&cnt_q[i]) && req_pulse[i] && !(grant && gidx == ID_W'(i));
      cnt_d[i] = ovf_d[i] ? cnt_q[i]
               : cnt_q[i] + CNT_W'(req_pulse[i]) - CNT_W'(grant && gidx == ID_W'(i));
      ovf_d[i] = ovf_d[i] | (ovf_q[i] & ~clr_ovf);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      ovf_q   <= '0;
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      ovf_q   <= ovf_d;
      busy_q  <= (|nz) || (state_q != IDLE);
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          state_q <= ISSUE;
          pulse_q <= 1'b1;
          id_q    <= gidx;
          ptr_q   <= gidx;
        end
        ISSUE: begin
          gap_q   <= GAP_LD;
          state_q <= MIN_GAP > 2 ? GAP : IDLE;
        end
        GAP: begin
          gap_q   <= gap_q - GW'(1);
          state_q <= gap_q == '0 ? IDLE : GAP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pulse_out = pulse_q;
  assign pulse_id  = id_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
`ifdef CDC_PULSE_SCHED_STATS_EN
  logic [15:0] issued_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) issued_q <= '0;
    else if (pulse_q) issued_q <= issued_q + 16'd1;
  end
  assign issued_cnt = issued_q;
`else
  assign issued_cnt = '0;
`endif
endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// tb_cdc_pulse_scheduler: directed scoreboard bench; expected (cycle, id) pulses are queued by stimulus and popped by a monitor.
module tb_cdc_pulse_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_pulse = '0;
  logic        clr_ovf = 1'b0;
  logic        pulse_out;
  logic [1:0]  pulse_id;
  logic        busy;
  logic [3:0]  overflow;
  logic [15:0] issued_cnt;

  typedef struct {int at; int id;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int c;

  cdc_pulse_scheduler #(.NUM_REQ(4), .MIN_GAP(6), .CNT_W(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse), .clr_ovf(clr_ovf),
    .pulse_out(pulse_out), .pulse_id(pulse_id), .busy(busy),
    .overflow(overflow), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pulse_out) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d id=%0d", cyc, pulse_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.at != cyc || e.id != int'(pulse_id)) begin
          bad++;
          $display("FAIL pulse got cyc=%0d id=%0d want cyc=%0d id=%0d", cyc, pulse_id, e.at, e.id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input int id);
    exp_t e;
    e.at = at;
    e.id = id;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_pulse"}, int'(pulse_out), 0);
    chk({name, "_id"}, int'(pulse_id), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_ovf"}, int'(overflow), 0);
    chk({name, "_issued"}, int'(issued_cnt), 0);
  endtask

  task automatic do_reset();
    req_pulse = '0;
    clr_ovf = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && sb.size() > 0; i++) step();
    chk({name, "_pending"}, sb.size(), 0);
    repeat (12) step();
  endtask

  initial begin
    do_reset();
    chk_idle("reset");

    // 1: single event on source 2
    repeat (6) step();
    c = cyc;
    push(c + 2, 2);
    req_pulse = 4'b0100;
    step();
    req_pulse = '0;
    repeat (6) step();
    chk("t1_busy_in_gap", int'(busy), 1);
    step();
    chk("t1_busy_after_gap", int'(busy), 0);
    drain("t1");

    // 2: all four at once
    do_reset();
    c = cyc;
    for (int k = 0; k < 4; k++) push(c + 2 + 6 * k, k);
    req_pulse = 4'b1111;
    step();
    req_pulse = '0;
    drain("t2");

    // 3: RR interleave 1,3,1,1
    do_reset();
    c = cyc;
    push(c + 2, 1); push(c + 8, 3); push(c + 14, 1); push(c + 20, 1);
    req_pulse = 4'b0010;
    repeat (3) step();
    req_pulse = 4'b1000;
    step();
    req_pulse = '0;
    drain("t3");

    // 4: saturation of source 0 while 1,2,3 are served first
    do_reset();
    c = cyc;
    push(c + 2, 1); push(c + 8, 2); push(c + 14, 3);
    for (int k = 0; k < 15; k++) push(c + 20 + 6 * k, 0);
    req_pulse = 4'b1110;
    step();
    req_pulse = 4'b0001;
    repeat (15) step();
    chk("t4_ovf_at_15", int'(overflow), 0);
    step();
    req_pulse = '0;
    chk("t4_ovf_set", int'(overflow), 1);
    repeat (5) step();
    chk("t4_ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", int'(overflow), 0);
    drain("t4");

    // 5: request coincides with grant at count 1
    do_reset();
    c = cyc;
    push(c + 2, 0); push(c + 8, 0);
    req_pulse = 4'b0001;
    repeat (2) step();
    req_pulse = '0;
    drain("t5");
    chk("t5_busy_end", int'(busy), 0);

    // 6: reset mid-GAP with 5 pending
    do_reset();
    c = cyc;
    push(c + 2, 0);
    req_pulse = 4'b0001;
    repeat (6) step();
    req_pulse = '0;
    chk("t6_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_idle("t6_rst");
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("t6_busy_after", int'(busy), 0);
    chk("t6_issued_after", int'(issued_cnt), 0);
    chk("t6_pending", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
